// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU datapath.
//   DATA_WIDTH - width of the ripple-carry adder built from full_adder_1_bit
//                cells. The 1-bit cell itself does not depend on it.
package alu_pkg;

  localparam int DATA_WIDTH = 32;

endpackage : alu_pkg

// File: rtl/half_adder.sv
// half_adder: single-bit half adder.
// Ports:
//   a, b  in   operand bits
//   s     out  a ^ b (also the "propagate" term when used on operands)
//   c     out  a & b (also the "generate" term when used on operands)
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder

// File: rtl/full_adder_1_bit.sv
// full_adder_1_bit: leaf cell of the ALU ripple-carry adder.
// Ports:
//   clk      in   clock for the registered outputs only
//   rst      in   synchronous active-high reset, clears Sum_q/Carry_q
//   A, B     in   operand bits
//   Cin      in   carry-in from the less-significant stage (0 for bit 0)
//   en       in   load enable for Sum_q/Carry_q
//   Sum      out  combinational A ^ B ^ Cin
//   Carry    out  combinational carry-out
//   Sum_q    out  Sum captured on a rising clk with en = 1
//   Carry_q  out  Carry captured on a rising clk with en = 1
module full_adder_1_bit
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic Cin,
  input  logic en,
  output logic Sum,
  output logic Carry,
  output logic Sum_q,
  output logic Carry_q
);

  logic p;          // propagate: A ^ B
  logic g;          // generate:  A & B
  logic c2;         // p & Cin
  logic sum_reg;
  logic carry_reg;

  // First half adder yields propagate/generate so a lookahead wrapper can
  // tap the same terms.
  half_adder u_ha_pg (
    .a (A),
    .b (B),
    .s (p),
    .c (g)
  );

  // Second half adder folds in the carry-in; its AND output keeps
  // Cin -> Carry to a single AND-OR level for the ripple chain.
  half_adder u_ha_cin (
    .a (p),
    .b (Cin),
    .s (Sum),
    .c (c2)
  );

  assign Carry = g | c2;

  // Reset takes priority over the load enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg   <= 1'b0;
      carry_reg <= 1'b0;
    end else if (en) begin
      sum_reg   <= Sum;
      carry_reg <= Carry;
    end
  end

  assign Sum_q   = sum_reg;
  assign Carry_q = carry_reg;

endmodule : full_adder_1_bit

// File: tb/tb_full_adder_1_bit.sv
module tb_full_adder_1_bit;

  logic clk;
  logic rst;
  logic a, b, cin, en;
  logic sum, carry, sum_q, carry_q;

  // 4-bit ripple chain built from the same cell
  logic [3:0] a4, b4;
  logic       c0;
  logic [3:0] s4;
  logic [4:0] cc;

  int tests;
  int fails;

  // behavioural model of the registered outputs
  logic m_sq, m_cq;
  bit   m_valid;

  logic [2:0] sweep_in  [8];
  logic [1:0] sweep_exp [8];

  full_adder_1_bit dut (
    .clk     (clk),
    .rst     (rst),
    .A       (a),
    .B       (b),
    .Cin     (cin),
    .en      (en),
    .Sum     (sum),
    .Carry   (carry),
    .Sum_q   (sum_q),
    .Carry_q (carry_q)
  );

  assign cc[0] = c0;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chain
      full_adder_1_bit u_fa (
        .clk     (clk),
        .rst     (rst),
        .A       (a4[gi]),
        .B       (b4[gi]),
        .Cin     (cc[gi]),
        .en      (1'b0),
        .Sum     (s4[gi]),
        .Carry   (cc[gi+1]),
        .Sum_q   (),
        .Carry_q ()
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the arithmetic model.
  task automatic compare();
    logic [1:0] e2;
    logic [4:0] e5;
    e2 = 2'({1'b0, a} + {1'b0, b} + {1'b0, cin});
    e5 = {1'b0, a4} + {1'b0, b4} + {4'b0, c0};
    check("comb", {6'b0, carry, sum}, {6'b0, e2});
    check("chain", {3'b0, cc[4], s4}, {3'b0, e5});
    if (m_valid)
      check("reg", {6'b0, carry_q, sum_q}, {6'b0, m_cq, m_sq});
  endtask

  // Apply inputs, let one rising edge pass, update model, compare at negedge.
  task automatic step(input logic ai, input logic bi, input logic ci,
                      input logic eni, input logic rsti);
    logic [1:0] e2;
    a = ai; b = bi; cin = ci; en = eni; rst = rsti;
    @(posedge clk);
    e2 = 2'({1'b0, a} + {1'b0, b} + {1'b0, cin});
    if (rst) begin
      m_sq = 1'b0; m_cq = 1'b0; m_valid = 1'b1;
    end else if (en) begin
      m_sq = e2[0]; m_cq = e2[1];
    end
    @(negedge clk);
    compare();
    $display("[TB] t=%0t rst=%0b en=%0b ABC=%0b%0b%0b Sum=%0b Carry=%0b Sum_q=%0b Carry_q=%0b",
             $time, rst, en, a, b, cin, sum, carry, sum_q, carry_q);
  endtask

  initial begin
    tests = 0; fails = 0; m_valid = 1'b0; m_sq = 1'b0; m_cq = 1'b0;
    a = 0; b = 0; cin = 0; en = 0; rst = 0;
    a4 = 4'h0; b4 = 4'h0; c0 = 1'b0;
    sweep_in[0] = 3'b000; sweep_exp[0] = 2'b00;
    sweep_in[1] = 3'b100; sweep_exp[1] = 2'b01;
    sweep_in[2] = 3'b010; sweep_exp[2] = 2'b01;
    sweep_in[3] = 3'b110; sweep_exp[3] = 2'b10;
    sweep_in[4] = 3'b111; sweep_exp[4] = 2'b11;
    sweep_in[5] = 3'b001; sweep_exp[5] = 2'b01;
    sweep_in[6] = 3'b011; sweep_exp[6] = 2'b10;
    sweep_in[7] = 3'b101; sweep_exp[7] = 2'b10;
    @(negedge clk);

    // reset for two edges
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("reset_q", {6'b0, carry_q, sum_q}, 8'h00);

    // exhaustive sweep, literal expectations
    for (int i = 0; i < 8; i++) begin
      step(sweep_in[i][2], sweep_in[i][1], sweep_in[i][0], 0, 0);
      check("sweep", {6'b0, carry, sum}, {6'b0, sweep_exp[i]});
    end

    // directed sequence
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0); check("dir_100", {6'b0, carry, sum}, 8'h01);
    step(0, 1, 0, 0, 0); check("dir_010", {6'b0, carry, sum}, 8'h01);
    step(1, 1, 0, 0, 0); check("dir_110", {6'b0, carry, sum}, 8'h02);
    step(1, 1, 1, 0, 0); check("dir_111", {6'b0, carry, sum}, 8'h03);

    // registered load
    step(1, 1, 1, 1, 0);
    check("load_q", {6'b0, carry_q, sum_q}, 8'h03);

    // hold with en=0 for 3 edges
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      check("hold_q", {6'b0, carry_q, sum_q}, 8'h03);
      check("hold_comb", {6'b0, carry, sum}, 8'h00);
    end

    // reset wins over enable
    step(1, 1, 0, 1, 1);
    check("prio_q", {6'b0, carry_q, sum_q}, 8'h00);
    check("prio_comb", {6'b0, carry, sum}, 8'h02);

    // chain: F + 1 = 0 carry 1
    a4 = 4'hF; b4 = 4'h1; c0 = 1'b0;
    step(0, 0, 0, 0, 0);
    check("chain_F1", {3'b0, cc[4], s4}, 8'h10);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
      c0 = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_full_adder_1_bit
